if_prefetch: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register and replaces the bare PC register, PC+4 adder and combinational ROM read.
- Issues requests to a variable-latency instruction memory and buffers returned words in a small FIFO.
- Presents one instruction per cycle, with its PC+4, to the decode stage.
- Handles branch redirects (taken-branch target from MEM) by flushing the buffer and discarding any in-flight response.

---
 rtl/if_prefetch_pkg.sv | 12 +
 rtl/if_prefetch_sync_fifo.sv | 59 +++++
 rtl/if_prefetch.sv | 115 +++++++++++
 tb/tb_if_prefetch.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_prefetch_pkg.sv
// Shared definitions for the instruction-fetch prefetch front end.
package if_prefetch_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

    localparam logic [31:0] INSTR_NOP  = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/if_prefetch_sync_fifo.sv
// Synchronous FIFO with flush; head entry is read combinationally (no bypass).
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign pop_ok  = pop && !empty && !flush;
    assign push_ok = push && !flush && (!full || pop_ok);
    assign rdata   = mem[rd_ptr];

    // NOTE: storage is not reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: sequential state uses <= so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push_ok && !pop_ok) begin
                count <= count + CNT_ONE;
            end else if (!push_ok && pop_ok) begin
                count <= count - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/if_prefetch.sv
// Fetch front end: issues requests to a variable-latency imem, buffers words,
// and presents one instruction plus its PC+4 per cycle to decode.
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          AW       = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc4
);

    localparam logic [AW:0] LAST_FREE = (AW+1)'(DEPTH - 1);

    fetch_state_t state, state_next;
    logic [31:0]  fetch_pc, fetch_pc_next;
    logic [31:0]  addr_next;
    logic         req_next;
    logic [31:0]  redirect_tgt;
    logic         push, pop;
    logic [AW:0]  count;
    logic         fifo_full, fifo_empty;
    logic [63:0]  head;

    assign redirect_tgt = redirect_pc & ~32'h3;
    assign out_valid    = !fifo_empty;
    assign pop          = out_valid && !stall;
    assign out_instr    = out_valid ? head[63:32] : INSTR_NOP;
    assign out_pc4      = out_valid ? head[31:0]  : INSTR_NOP;

    sync_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redirect),
        .push  (push),
        .pop   (pop),
        .wdata ({imem_rdata, imem_addr + WORD_BYTES}),
        .rdata (head),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_next;
    end

    // Only a redirect that strands an unacked request needs to wait out its response.
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (redirect && imem_req && !imem_ack) state_next = DRAIN;
            DRAIN:   if (imem_ack) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        push          = 1'b0;
        req_next      = imem_req;
        addr_next     = imem_addr;
        fetch_pc_next = fetch_pc;
        if (redirect) begin
            fetch_pc_next = redirect_tgt;
            if (!(imem_req && !imem_ack)) begin
                req_next  = 1'b1;
                addr_next = redirect_tgt;
            end
        end else if (state == DRAIN) begin
            if (imem_ack) begin
                req_next  = 1'b1;
                addr_next = fetch_pc;
            end
        end else if (imem_req && imem_ack) begin
            push          = 1'b1;
            fetch_pc_next = fetch_pc + WORD_BYTES;
            // After this push the count is count+1-pop; relaunch only if that leaves room.
            req_next      = pop || (count < LAST_FREE);
            if (req_next) addr_next = fetch_pc + WORD_BYTES;
        end else if (!imem_req) begin
            req_next = pop || !fifo_full;
            if (req_next) addr_next = fetch_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            fetch_pc  <= RESET_PC;
        end else begin
            imem_req  <= req_next;
            imem_addr <= addr_next;
            fetch_pc  <= fetch_pc_next;
        end
    end

endmodule

// File: tb/tb_if_prefetch.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_if_prefetch;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, redirect, stall, imem_ack;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, out_valid;
    logic [31:0] imem_addr, out_instr, out_pc4;

    if_prefetch #(.DEPTH(DEPTH), .AW(2), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .out_valid   (out_valid),
        .out_instr   (out_instr),
        .out_pc4     (out_pc4)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Memory responder: wait-state policy 0 = zero-wait, 1 = fixed, 2 = random 0..3.
    int          mem_mode;
    int          fixed_wait;
    int          wait_left;
    int          n_acks;
    bit          pending;
    logic [31:0] held_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic drive_mem();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        if (reset) begin
            pending = 1'b0;
        end else if (imem_req) begin
            if (!pending) begin
                pending   = 1'b1;
                held_addr = imem_addr;
                wait_left = (mem_mode == 0) ? 0 :
                            (mem_mode == 1) ? fixed_wait : int'($urandom_range(0, 3));
            end else begin
                check("addr_hold", imem_addr, held_addr);
            end
            if (wait_left == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                pending    = 1'b0;
                n_acks++;
            end else begin
                wait_left--;
            end
        end
    endtask

    // Reference model: FIFO contents as a queue of {instr, pc4}, plus request bookkeeping.
    logic [63:0] mq[$];
    bit          m_req, m_drain;
    logic [31:0] m_addr, m_fetch;

    task automatic model_step();
        bit do_pop;
        do_pop = (mq.size() != 0) && !stall;
        if (reset) begin
            mq.delete();
            m_req   = 1'b0;
            m_drain = 1'b0;
            m_addr  = RESET_PC;
            m_fetch = RESET_PC;
        end else if (redirect) begin
            mq.delete();
            m_fetch = redirect_pc & ~32'h3;
            if (m_req && !imem_ack) begin
                m_drain = 1'b1;
            end else begin
                m_drain = 1'b0;
                m_req   = 1'b1;
                m_addr  = m_fetch;
            end
        end else if (m_drain) begin
            if (imem_ack) begin
                m_drain = 1'b0;
                m_req   = 1'b1;
                m_addr  = m_fetch;
            end
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (m_req && imem_ack) begin
                mq.push_back({imem_rdata, m_addr + 32'd4});
                m_fetch = m_fetch + 32'd4;
            end
            if (!(m_req && !imem_ack)) begin
                m_req = (mq.size() < DEPTH);
                if (m_req) m_addr = m_fetch;
            end
        end
    endtask

    task automatic check_outputs();
        logic [63:0] h;
        h = (mq.size() != 0) ? mq[0] : 64'h0;
        check("req", 32'(imem_req), 32'(m_req));
        if (m_req) check("addr", imem_addr, m_addr);
        check("valid", 32'(out_valid), 32'(mq.size() != 0));
        check("instr", out_instr, h[63:32]);
        check("pc4", out_pc4, h[31:0]);
    endtask

    task automatic step();
        drive_mem();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        redirect = 1'b0;
        stall    = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit found;
        int a;
        reset = 1'b1; redirect = 1'b0; stall = 1'b0; redirect_pc = '0;
        imem_ack = 1'b0; imem_rdata = '0;
        mem_mode = 0; fixed_wait = 0; wait_left = 0; n_acks = 0; pending = 1'b0;
        @(negedge clk);

        // Reset state
        do_reset();
        check("rst_req", 32'(imem_req), 32'(0));
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_valid", 32'(out_valid), 32'(0));
        check("rst_instr", out_instr, 32'h0);

        // Zero-wait streaming, no stall
        step();
        check("t1_req", 32'(imem_req), 32'(1));
        check("t1_addr", imem_addr, 32'h0);
        check("t1_valid0", 32'(out_valid), 32'(0));
        for (int k = 2; k <= 5; k++) begin
            step();
            check("t1_valid", 32'(out_valid), 32'(1));
            check("t1_pc4", out_pc4, 32'(4 * (k - 1)));
        end

        // Stall held: fill to DEPTH, then drain in order
        do_reset();
        stall  = 1'b1;
        n_acks = 0;
        repeat (10) step();
        check("t2_acks", 32'(n_acks), 32'(4));
        check("t2_req_idle", 32'(imem_req), 32'(0));
        check("t2_head", out_pc4, 32'h4);
        stall = 1'b0;
        step();
        check("t2_resume_req", 32'(imem_req), 32'(1));
        check("t2_resume_addr", imem_addr, 32'h10);
        for (int k = 0; k < 4; k++) begin
            check("t2_order", out_pc4, 32'(8 + 4 * k));
            step();
        end

        // Three wait states: one push per four cycles
        mem_mode   = 1;
        fixed_wait = 3;
        do_reset();
        n_acks = 0;
        repeat (40) step();
        check("t3_acks", 32'(n_acks), 32'(9));

        // Redirect while the request for 0x8 is outstanding
        fixed_wait = 5;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            if (imem_req && imem_addr == 32'h8) found = 1'b1;
        end
        check("t4_found", 32'(found), 32'(1));
        redirect = 1'b1; redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        check("t4_flush", 32'(out_valid), 32'(0));
        check("t4_hold_req", 32'(imem_req), 32'(1));
        check("t4_hold_addr", imem_addr, 32'h8);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            a = n_acks;
            step();
            if (n_acks != a) found = 1'b1;
        end
        check("t4_drained", 32'(found), 32'(1));
        check("t4_new_req", 32'(imem_req), 32'(1));
        check("t4_new_addr", imem_addr, 32'h100);
        check("t4_discard", 32'(out_valid), 32'(0));
        for (int i = 0; i < 20 && !out_valid; i++) step();
        check("t4_first_pc4", out_pc4, 32'h104);

        // Redirect coinciding with ack and a pending pop
        mem_mode = 0;
        do_reset();
        repeat (4) step();
        check("t5_pre_valid", 32'(out_valid), 32'(1));
        redirect = 1'b1; redirect_pc = 32'h200;
        step();
        redirect = 1'b0;
        check("t5_valid", 32'(out_valid), 32'(0));
        check("t5_req", 32'(imem_req), 32'(1));
        check("t5_addr", imem_addr, 32'h200);
        step();
        check("t5_valid2", 32'(out_valid), 32'(1));
        check("t5_pc4", out_pc4, 32'h204);

        // Reset while draining with the request still up
        mem_mode   = 1;
        fixed_wait = 5;
        do_reset();
        repeat (3) step();
        redirect = 1'b1; redirect_pc = 32'h300;
        step();
        redirect = 1'b0;
        check("t6_drain_req", 32'(imem_req), 32'(1));
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_req", 32'(imem_req), 32'(0));
        check("t6_addr", imem_addr, RESET_PC);
        check("t6_valid", 32'(out_valid), 32'(0));
        step();
        check("t6_restart_req", 32'(imem_req), 32'(1));
        check("t6_restart_addr", imem_addr, RESET_PC);
        repeat (12) step();

        // Randomized traffic: random waits, stalls, redirects (unaligned targets), resets
        mem_mode = 2;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            stall       = ($urandom_range(0, 9) < 3);
            redirect    = ($urandom_range(0, 99) < 5);
            redirect_pc = $urandom;
            reset       = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0; redirect = 1'b0; stall = 1'b0;
        repeat (8) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
